// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - per-cycle pc/probe event tracer with circular buffer and readback
// Optional feature: TRACE_TRIGGER_EN adds trig_pc and the ARMED state (start on pc match).
module pipeline_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int NPROBE = 2,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int E_W   = CYC_W + DATA_W + NPROBE + NPROBE * DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clr,
  input  logic                     mode_wrap,
  input  logic [CYC_W-1:0]         stop_cycle,
  input  logic [DATA_W-1:0]        pc,
`ifdef TRACE_TRIGGER_EN
  input  logic [DATA_W-1:0]        trig_pc,
`endif
  input  logic [NPROBE-1:0]        probe_vld,
  input  logic [NPROBE*DATA_W-1:0] probe_data,
  input  logic                     rd_req,
  input  logic [AW-1:0]            rd_addr,
  output logic [E_W-1:0]           rd_data,
  output logic                     rd_valid,
  output logic [CYC_W-1:0]         cycle,
  output logic [AW:0]              count,
  output logic                     overflow,
  output logic                     done,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DONE  = 2'b10,
    S_ARMED = 2'b11
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  state_t            st, st_nxt;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] last_pc;
  logic [E_W-1:0]    mem [DEPTH];

  logic [CYC_W-1:0]  stamp;
  logic              active;
  logic              capture;
  logic              full;
  logic              blocked;
  logic              wr_en;
  logic              stop_hit;
  logic              fill_stop;
  logic [AW-1:0]     phys_addr;
  logic [E_W-1:0]    entry;

  // Stamp for the current cycle; the counter saturates rather than wrapping.
  assign stamp     = (&cycle) ? cycle : cycle + CYC_W'(1);
  assign capture   = (|probe_vld) || (pc != last_pc);
  assign full      = (count == FULL_CNT);
  assign blocked   = full && !mode_wrap;
  assign wr_en     = active && capture && !blocked && !clr;
  assign stop_hit  = (stop_cycle != '0) && (stamp == stop_cycle);
  assign fill_stop = blocked || (wr_en && !mode_wrap && (count == LAST_CNT));
  assign entry     = {stamp, pc, probe_vld, probe_data};
  assign phys_addr = (full ? wr_ptr : '0) + rd_addr;
  assign done      = (st == S_DONE);
  assign state     = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    active = 1'b0;
    case (st)
      S_IDLE: begin
`ifdef TRACE_TRIGGER_EN
        if (enable) st_nxt = S_ARMED;
`else
        if (enable) st_nxt = S_RUN;
`endif
      end
      S_RUN: begin
        if (!enable) begin
          st_nxt = S_IDLE;
        end else begin
          active = 1'b1;
          if (stop_hit || fill_stop) st_nxt = S_DONE;
        end
      end
      S_ARMED: begin
`ifdef TRACE_TRIGGER_EN
        // The trigger-hit cycle is already a traced cycle (stamp 1, first capture).
        if (!enable) begin
          st_nxt = S_IDLE;
        end else if (pc == trig_pc) begin
          active = 1'b1;
          st_nxt = (stop_hit || fill_stop) ? S_DONE : S_RUN;
        end
`else
        st_nxt = S_IDLE;
`endif
      end
      default: st_nxt = st;
    endcase
    if (clr) st_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      last_pc  <= '0;
    end else if (clr) begin
      cycle    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      last_pc  <= '0;
    end else begin
      if (active) begin
        cycle   <= stamp;
        last_pc <= pc;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset and clr so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= ({1'b0, rd_addr} >= count) ? '0 : mem[phys_addr];
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - directed scoreboard bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;
  localparam int DATA_W = 32;
  localparam int NPROBE = 2;
  localparam int DEPTH  = 16;
  localparam int CYC_W  = 32;
  localparam int AW     = 4;
  localparam int E_W    = CYC_W + DATA_W + NPROBE + NPROBE * DATA_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     enable = 1'b0;
  logic                     clr = 1'b0;
  logic                     mode_wrap = 1'b0;
  logic [CYC_W-1:0]         stop_cycle = '0;
  logic [DATA_W-1:0]        pc = '0;
`ifdef TRACE_TRIGGER_EN
  logic [DATA_W-1:0]        trig_pc = '0;
`endif
  logic [NPROBE-1:0]        probe_vld = '0;
  logic [NPROBE*DATA_W-1:0] probe_data = '0;
  logic                     rd_req = 1'b0;
  logic [AW-1:0]            rd_addr = '0;
  logic [E_W-1:0]           rd_data;
  logic                     rd_valid;
  logic [CYC_W-1:0]         cycle;
  logic [AW:0]              count;
  logic                     overflow;
  logic                     done;
  logic [1:0]               state;

  int errors = 0;
  int checks = 0;
  logic [E_W-1:0] sb[$];

  pipeline_trace_buffer #(
    .DATA_W(DATA_W), .NPROBE(NPROBE), .DEPTH(DEPTH), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .mode_wrap(mode_wrap),
    .stop_cycle(stop_cycle), .pc(pc),
`ifdef TRACE_TRIGGER_EN
    .trig_pc(trig_pc),
`endif
    .probe_vld(probe_vld), .probe_data(probe_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .cycle(cycle), .count(count),
    .overflow(overflow), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [E_W-1:0] mk(input int stamp, input int pcv,
                                        input logic [NPROBE-1:0] vld,
                                        input logic [NPROBE*DATA_W-1:0] data);
    return {CYC_W'(stamp), DATA_W'(pcv), vld, data};
  endfunction

  task automatic chk(input string tag, input logic [E_W-1:0] obs, input logic [E_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_entry(input int idx, input string tag);
    logic [E_W-1:0] exp;
    rd_req  = 1'b1;
    rd_addr = AW'(idx);
    tick();
    rd_req = 1'b0;
    exp = (sb.size() > 0) ? sb.pop_front() : {E_W{1'b1}};
    chk({tag, "_vld"}, E_W'(rd_valid), E_W'(1));
    chk(tag, rd_data, exp);
  endtask

  initial begin
    // 1: reset state, then three pc steps
    tick();
    tick();
    chk("rst_state", E_W'(state), E_W'(0));
    chk("rst_count", E_W'(count), E_W'(0));
    chk("rst_cycle", E_W'(cycle), E_W'(0));
    chk("rst_done", E_W'(done), E_W'(0));
    chk("rst_ovf", E_W'(overflow), E_W'(0));
    chk("rst_rdv", E_W'(rd_valid), E_W'(0));
    chk("rst_rdd", rd_data, '0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      pc = DATA_W'(228 + 4 * i);
      sb.push_back(mk(i + 1, 228 + 4 * i, '0, '0));
      tick();
    end
    chk("t1_count", E_W'(count), E_W'(3));
    chk("t1_cycle", E_W'(cycle), E_W'(3));
    chk("t1_state", E_W'(state), E_W'(1));
    enable = 1'b0;
    tick();
    chk("t1_pause", E_W'(state), E_W'(0));
    for (int i = 0; i < 3; i++) read_entry(i, "t1_rd");
    sb.push_back('0);
    read_entry(3, "t1_rd_past_count");

    // 2: stop when full
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mode_wrap = 1'b0;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      pc = DATA_W'(1000 + 4 * i);
      if (i < 16) sb.push_back(mk(i + 1, 1000 + 4 * i, '0, '0));
      tick();
      if (i == 14) chk("t2_done_early", E_W'(done), E_W'(0));
      if (i == 15) chk("t2_done_at_full", E_W'(done), E_W'(1));
    end
    enable = 1'b0;
    chk("t2_count", E_W'(count), E_W'(16));
    chk("t2_cycle", E_W'(cycle), E_W'(16));
    chk("t2_state", E_W'(state), E_W'(2));
    chk("t2_ovf", E_W'(overflow), E_W'(0));
    for (int i = 0; i < 16; i++) read_entry(i, "t2_rd");

    // 3: circular overwrite
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mode_wrap = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      pc = DATA_W'(2000 + 4 * i);
      if (i >= 4) sb.push_back(mk(i + 1, 2000 + 4 * i, '0, '0));
      tick();
    end
    enable = 1'b0;
    tick();
    chk("t3_count", E_W'(count), E_W'(16));
    chk("t3_ovf", E_W'(overflow), E_W'(1));
    chk("t3_cycle", E_W'(cycle), E_W'(20));
    chk("t3_state", E_W'(state), E_W'(0));
    for (int i = 0; i < 16; i++) read_entry(i, "t3_rd");

    // 4: stop_cycle with a probe event on the stop cycle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mode_wrap = 1'b0;
    stop_cycle = CYC_W'(8);
    enable = 1'b1;
    tick();
    for (int s = 1; s <= 12; s++) begin
      pc = DATA_W'(64);
      probe_vld  = (s == 8 || s == 10) ? 2'b01 : 2'b00;
      probe_data = (s == 8) ? 64'd2 : ((s == 10) ? 64'd9 : 64'd0);
      if (s == 1 || s == 8) sb.push_back(mk(s, 64, probe_vld, probe_data));
      tick();
    end
    probe_vld = '0;
    probe_data = '0;
    enable = 1'b0;
    chk("t4_done", E_W'(done), E_W'(1));
    chk("t4_count", E_W'(count), E_W'(2));
    chk("t4_cycle", E_W'(cycle), E_W'(8));
    read_entry(0, "t4_rd");
    read_entry(1, "t4_rd_stop");
    sb.push_back('0);
    read_entry(2, "t4_rd_none");

    // 5: clr beats enable and capture, then async reset mid-RUN
    stop_cycle = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    enable = 1'b1;
    tick();
    pc = DATA_W'(300);
    tick();
    chk("t5_count_pre", E_W'(count), E_W'(1));
    clr = 1'b1;
    pc = DATA_W'(304);
    probe_vld = 2'b01;
    tick();
    clr = 1'b0;
    probe_vld = '0;
    chk("t5_clr_count", E_W'(count), E_W'(0));
    chk("t5_clr_cycle", E_W'(cycle), E_W'(0));
    chk("t5_clr_state", E_W'(state), E_W'(0));
    tick();
    pc = DATA_W'(308);
    tick();
    pc = DATA_W'(312);
    tick();
    sb.push_back(mk(1, 308, '0, '0));
    read_entry(0, "t5_rd");
    chk("t5_count", E_W'(count), E_W'(2));
    chk("t5_state", E_W'(state), E_W'(1));
    rst_n = 1'b0;
    #2;
    chk("t5_rst_state", E_W'(state), E_W'(0));
    chk("t5_rst_count", E_W'(count), E_W'(0));
    chk("t5_rst_cycle", E_W'(cycle), E_W'(0));
    chk("t5_rst_rdd", rd_data, '0);
    chk("t5_rst_rdv", E_W'(rd_valid), E_W'(0));
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef TRACE_TRIGGER_EN
    // 6: trigger on pc match
    trig_pc = DATA_W'(104);
    enable = 1'b1;
    pc = DATA_W'(100);
    tick();
    chk("t6_armed", E_W'(state), E_W'(3));
    tick();
    chk("t6_still_armed", E_W'(state), E_W'(3));
    pc = DATA_W'(104);
    sb.push_back(mk(1, 104, '0, '0));
    tick();
    chk("t6_run", E_W'(state), E_W'(1));
    chk("t6_cycle", E_W'(cycle), E_W'(1));
    pc = DATA_W'(108);
    sb.push_back(mk(2, 108, '0, '0));
    tick();
    enable = 1'b0;
    tick();
    chk("t6_count", E_W'(count), E_W'(2));
    read_entry(0, "t6_rd");
    read_entry(1, "t6_rd");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
